frame_timer: RTL and testbench
==============================

FRAME_TIMER -- requirements
Module: frame_timer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports are named clk and rst.
REQ-002 Parameter CLK_HZ, default 1000000, SHALL be the clk frequency in Hz.
REQ-003 Parameter FPS, default 60, SHALL be the reset-time frame rate; PERIOD = CLK_HZ/FPS (integer division), required >= 2.
REQ-004 Parameter DIV_W, default 32, SHALL be the width of the period register, the cycle counter and period_in.
REQ-005 Parameter FRAME_W, default 32, SHALL be the width of frame_cnt.
REQ-006 Parameter OVR_W, default 8, SHALL be the width of ovr_cnt.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 en  input  1  1 = counter advances; 0 = counter freezes.
REQ-010 period_ld  input  1  loads period_in into the period register.
REQ-011 period_in  input  DIV_W  new period in clk cycles.
REQ-012 frame_ready  input  1  consumer accepts the pending frame.
REQ-013 tick  output  1  one-cycle pulse at each frame boundary.
REQ-014 frame_clk  output  1  toggles on every tick (50% duty frame clock).
REQ-015 frame_valid  output  1  a frame is pending for the consumer.
REQ-016 frame_cnt  output  FRAME_W  number of ticks since reset, modulo 2^FRAME_W.
REQ-017 overrun  output  1  one-cycle pulse when a tick arrives while a frame is still pending.
REQ-018 ovr_cnt  output  OVR_W  saturating count of overruns.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 Internal counter cnt counts 0..P-1, where P is the period register; at an edge with en=1 and cnt<P-1, cnt SHALL increment.
REQ-021 At an edge with en=1 and cnt==P-1, cnt SHALL wrap to 0 and tick SHALL be 1 for the following cycle; tick SHALL be 0 in every other cycle.
REQ-022 With en held at 1, ticks SHALL occur exactly every P edges; the first tick follows the P-th enabled edge after reset release.
REQ-023 With en=0, cnt SHALL hold and no tick SHALL be generated; handshake state is unaffected.
REQ-024 period_ld=1 at an edge SHALL load P <= max(period_in,2) and clear cnt to 0; no tick occurs at that edge, even if a wrap coincides. This applies regardless of en.
REQ-025 On each tick edge, frame_clk SHALL invert and frame_cnt SHALL increment, wrapping from all-ones to 0.
REQ-026 On a tick edge, frame_valid SHALL be set to 1.
REQ-027 On a non-tick edge, frame_valid=1 together with frame_ready=1 SHALL clear frame_valid.
REQ-028 On a tick edge where frame_valid=1 and frame_ready=0 (pre-edge values):
- overrun SHALL pulse for one cycle;
- ovr_cnt SHALL increment, saturating at 2^OVR_W-1;
- frame_valid SHALL stay 1.
REQ-029 On a tick edge where frame_valid=1 and frame_ready=1, the old frame completes, frame_valid stays 1 for the new frame, and no overrun occurs.
REQ-030 frame_ready while frame_valid=0 SHALL have no effect.

Reset
REQ-031 rst=1 at an edge SHALL force cnt=0, P=PERIOD, tick=0, frame_clk=0, frame_valid=0, frame_cnt=0, overrun=0 and ovr_cnt=0.
REQ-032 rst SHALL take priority over en, period_ld and frame_ready, including mid-period and mid-handshake.

Verification (CLK_HZ=600, FPS=60, so PERIOD=10, unless stated)
REQ-033 Release rst, en=1, frame_ready=1 -> tick after edges 10, 20 and 30; frame_cnt=1,2,3; frame_clk=1,0,1; frame_valid high one cycle each time; ovr_cnt=0.
REQ-034 Hold en=0 for 5 cycles once cnt=4 -> first tick moves from edge 10 to edge 15; frame_cnt is unchanged during the pause.
REQ-035 frame_ready=0 for edges 1-30, then 1 -> frame_valid high from edge 10; overrun pulses at edges 20 and 30; ovr_cnt=2; frame_valid clears at edge 31.
REQ-036 period_ld with period_in=1 -> P=2 and ticks every 2 edges; period_ld coincident with cnt==P-1 -> no tick at that edge and cnt=0.
REQ-037 OVR_W=2, frame_ready=0 for 6 periods -> overrun pulses 5 times and ovr_cnt saturates at 3.
REQ-038 rst asserted at cnt=7 with frame_valid=1 and period 4 loaded -> all outputs 0 next cycle; next tick 10 enabled edges after release.

Source files
------------

// File: rtl/frame_timer.sv
// Frame timer: programmable-period frame tick generator with a frame_clk
// divider, a frame counter and a valid/ready handshake with overrun tracking.
module frame_timer #(
    parameter int CLK_HZ  = 1000000,
    parameter int FPS     = 60,
    parameter int DIV_W   = 32,
    parameter int FRAME_W = 32,
    parameter int OVR_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               period_ld,
    input  logic [DIV_W-1:0]   period_in,
    input  logic               frame_ready,
    output logic               tick,
    output logic               frame_clk,
    output logic               frame_valid,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               overrun,
    output logic [OVR_W-1:0]   ovr_cnt
);

    localparam int               PERIOD      = CLK_HZ / FPS;
    localparam logic [DIV_W-1:0] PERIOD_INIT = DIV_W'(PERIOD);
    localparam logic [DIV_W-1:0] MIN_PERIOD  = DIV_W'(2);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        logic [OVR_W-1:0] r;
        if (v == {OVR_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + OVR_W'(1);
        end
        return r;
    endfunction

    logic [DIV_W-1:0]   period_r, period_nx_s;
    logic [DIV_W-1:0]   cnt_r, cnt_nx_s;
    logic               tick_r, tick_nx_s;
    logic               fclk_r, fclk_nx_s;
    logic               fvalid_r, fvalid_nx_s;
    logic [FRAME_W-1:0] fcnt_r, fcnt_nx_s;
    logic               ovr_r, ovr_nx_s;
    logic [OVR_W-1:0]   ovrcnt_r, ovrcnt_nx_s;
    logic               wrap_s;
    logic               tick_s;

    assign wrap_s = (cnt_r == (period_r - DIV_W'(1)));
    // A period load restarts the frame, so it suppresses a coincident wrap.
    assign tick_s = en & wrap_s & ~period_ld;

    // Period register and cycle counter next-state.
    always_comb begin
        period_nx_s = period_r;
        cnt_nx_s    = cnt_r;
        if (period_ld) begin
            period_nx_s = (period_in < MIN_PERIOD) ? MIN_PERIOD : period_in;
            cnt_nx_s    = '0;
        end else if (en) begin
            if (wrap_s) begin
                cnt_nx_s = '0;
            end else begin
                cnt_nx_s = cnt_r + DIV_W'(1);
            end
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    // Frame outputs and consumer handshake next-state.
    always_comb begin
        tick_nx_s   = tick_s;
        fclk_nx_s   = fclk_r;
        fvalid_nx_s = fvalid_r;
        fcnt_nx_s   = fcnt_r;
        ovr_nx_s    = 1'b0;
        ovrcnt_nx_s = ovrcnt_r;
        if (tick_s) begin
            fclk_nx_s   = ~fclk_r;
            fcnt_nx_s   = fcnt_r + FRAME_W'(1);
            fvalid_nx_s = 1'b1;
            ovr_nx_s    = fvalid_r & ~frame_ready;
            if (fvalid_r & ~frame_ready) begin
                ovrcnt_nx_s = sat_inc(ovrcnt_r);
            end else begin
                ovrcnt_nx_s = ovrcnt_r;
            end
        end else begin
            if (fvalid_r & frame_ready) begin
                fvalid_nx_s = 1'b0;
            end else begin
                fvalid_nx_s = fvalid_r;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_r <= PERIOD_INIT;
            cnt_r    <= '0;
            tick_r   <= 1'b0;
            fclk_r   <= 1'b0;
            fvalid_r <= 1'b0;
            fcnt_r   <= '0;
            ovr_r    <= 1'b0;
            ovrcnt_r <= '0;
        end else begin
            period_r <= period_nx_s;
            cnt_r    <= cnt_nx_s;
            tick_r   <= tick_nx_s;
            fclk_r   <= fclk_nx_s;
            fvalid_r <= fvalid_nx_s;
            fcnt_r   <= fcnt_nx_s;
            ovr_r    <= ovr_nx_s;
            ovrcnt_r <= ovrcnt_nx_s;
        end
    end

    assign tick        = tick_r;
    assign frame_clk   = fclk_r;
    assign frame_valid = fvalid_r;
    assign frame_cnt   = fcnt_r;
    assign overrun     = ovr_r;
    assign ovr_cnt     = ovrcnt_r;

endmodule

// File: tb/tb_frame_timer.sv
// Bench for frame_timer: directed vector table plus randomized traffic, all
// checked against a frame-level reference model (PERIOD=10, FRAME_W=4, OVR_W=2).
module tb_frame_timer;
    localparam int DIV_W   = 16;
    localparam int FRAME_W = 4;
    localparam int OVR_W   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               period_ld = 1'b0;
    logic [DIV_W-1:0]   period_in = '0;
    logic               frame_ready = 1'b0;
    logic               tick, frame_clk, frame_valid, overrun;
    logic [FRAME_W-1:0] frame_cnt;
    logic [OVR_W-1:0]   ovr_cnt;

    frame_timer #(.CLK_HZ(600), .FPS(60), .DIV_W(DIV_W), .FRAME_W(FRAME_W), .OVR_W(OVR_W)) dut (
        .clk(clk), .rst(rst), .en(en), .period_ld(period_ld), .period_in(period_in),
        .frame_ready(frame_ready), .tick(tick), .frame_clk(frame_clk),
        .frame_valid(frame_valid), .frame_cnt(frame_cnt), .overrun(overrun), .ovr_cnt(ovr_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: enabled edges since the last frame boundary.
    int   m_p = 10, m_phase = 0, m_fcnt = 0, m_ovrcnt = 0;
    logic m_tick = 1'b0, m_fclk = 1'b0, m_fv = 1'b0, m_ovr = 1'b0;

    logic [9:0] dut_s;
    assign dut_s = {tick, frame_clk, frame_valid, frame_cnt, overrun, ovr_cnt};

    typedef struct {
        string name;
        logic  rst, en, ld;
        int    pin;
        logic  rdy;
        int    reps;
        logic [9:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [9:0] e(input int t, input int fc, input int fv,
                                     input int cnt, input int ov, input int oc);
        return {1'(t), 1'(fc), 1'(fv), 4'(cnt), 1'(ov), 2'(oc)};
    endfunction

    function automatic logic [9:0] model_out();
        return {m_tick, m_fclk, m_fv, 4'(m_fcnt), m_ovr, 2'(m_ovrcnt)};
    endfunction

    task automatic add(input string n, input int r, input int en_v, input int ld_v,
                       input int pin_v, input int rdy_v, input int reps, input logic [9:0] x);
        vec_t v;
        v.name = n; v.rst = 1'(r); v.en = 1'(en_v); v.ld = 1'(ld_v);
        v.pin = pin_v; v.rdy = 1'(rdy_v); v.reps = reps; v.exp = x;
        tbl.push_back(v);
    endtask

    task automatic check(input string n, input logic [9:0] x);
        n_vec++;
        if (dut_s !== x) begin
            n_err++;
            $display("FAIL %s: got {tick,fclk,fvalid,fcnt,ovr,ovrcnt}=%b, expected %b", n, dut_s, x);
        end
    endtask

    task automatic model_edge();
        logic b;
        b = 1'b0;
        if (rst) begin
            m_p = 10; m_phase = 0; m_tick = 1'b0; m_fclk = 1'b0; m_fv = 1'b0;
            m_fcnt = 0; m_ovr = 1'b0; m_ovrcnt = 0;
        end else begin
            if (period_ld) begin
                m_p = (int'(period_in) < 2) ? 2 : int'(period_in);
                m_phase = 0;
            end else if (en) begin
                m_phase++;
                if (m_phase == m_p) begin
                    b = 1'b1;
                    m_phase = 0;
                end
            end
            m_ovr = b && m_fv && !frame_ready;
            if (b) begin
                if (m_ovr && m_ovrcnt < 3) m_ovrcnt++;
                m_fv = 1'b1;
                m_fcnt = (m_fcnt + 1) % 16;
                m_fclk = !m_fclk;
            end else if (m_fv && frame_ready) begin
                m_fv = 1'b0;
            end
            m_tick = b;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check("model", model_out());
    endtask

    initial begin
        // basic run, ready always high
        add("rst_a",   1, 0, 0, 0, 1, 2,  e(0,0,0,0,0,0));
        add("run9",    0, 1, 0, 0, 1, 9,  e(0,0,0,0,0,0));
        add("tick10",  0, 1, 0, 0, 1, 1,  e(1,1,1,1,0,0));
        add("clr11",   0, 1, 0, 0, 1, 1,  e(0,1,0,1,0,0));
        add("tick20",  0, 1, 0, 0, 1, 9,  e(1,0,1,2,0,0));
        add("tick30",  0, 1, 0, 0, 1, 10, e(1,1,1,3,0,0));
        // pause with en low
        add("rst_b",   1, 0, 0, 0, 1, 1,  e(0,0,0,0,0,0));
        add("pre4",    0, 1, 0, 0, 1, 4,  e(0,0,0,0,0,0));
        add("pause",   0, 0, 0, 0, 1, 5,  e(0,0,0,0,0,0));
        add("pre14",   0, 1, 0, 0, 1, 5,  e(0,0,0,0,0,0));
        add("tick15",  0, 1, 0, 0, 1, 1,  e(1,1,1,1,0,0));
        // consumer stalls
        add("rst_c",   1, 0, 0, 0, 1, 1,  e(0,0,0,0,0,0));
        add("nr10",    0, 1, 0, 0, 0, 10, e(1,1,1,1,0,0));
        add("ovr20",   0, 1, 0, 0, 0, 10, e(1,0,1,2,1,1));
        add("ovr30",   0, 1, 0, 0, 0, 10, e(1,1,1,3,1,2));
        add("clr31",   0, 1, 0, 0, 1, 1,  e(0,1,0,3,0,2));
        // overrun counter saturation
        add("rst_d",   1, 0, 0, 0, 1, 1,  e(0,0,0,0,0,0));
        add("sat60",   0, 1, 0, 0, 0, 60, e(1,0,1,6,1,3));
        // period load clamp and load colliding with a wrap
        add("rst_e",   1, 0, 0, 0, 1, 1,  e(0,0,0,0,0,0));
        add("ld1",     0, 0, 1, 1, 1, 1,  e(0,0,0,0,0,0));
        add("p2a",     0, 1, 0, 0, 1, 1,  e(0,0,0,0,0,0));
        add("p2t1",    0, 1, 0, 0, 1, 1,  e(1,1,1,1,0,0));
        add("p2b",     0, 1, 0, 0, 1, 1,  e(0,1,0,1,0,0));
        add("p2t2",    0, 1, 0, 0, 1, 1,  e(1,0,1,2,0,0));
        add("p2c",     0, 1, 0, 0, 1, 1,  e(0,0,0,2,0,0));
        add("ldwrap",  0, 1, 1, 5, 1, 1,  e(0,0,0,2,0,0));
        add("p5pre",   0, 1, 0, 0, 1, 4,  e(0,0,0,2,0,0));
        add("p5t",     0, 1, 0, 0, 1, 1,  e(1,1,1,3,0,0));
        // reset mid-period / mid-handshake, with a coincident load
        add("rst_f",   1, 0, 0, 0, 1, 1,  e(0,0,0,0,0,0));
        add("mid17",   0, 1, 0, 0, 0, 17, e(0,1,1,1,0,0));
        add("rstld",   1, 1, 1, 4, 1, 1,  e(0,0,0,0,0,0));
        add("rel9",    0, 1, 0, 0, 1, 9,  e(0,0,0,0,0,0));
        add("rel10",   0, 1, 0, 0, 1, 1,  e(1,1,1,1,0,0));
        // frame counter wrap with period_in=0 clamped to 2
        add("rst_g",   1, 0, 0, 0, 1, 1,  e(0,0,0,0,0,0));
        add("ld0",     0, 0, 1, 0, 1, 1,  e(0,0,0,0,0,0));
        add("wrap32",  0, 1, 0, 0, 1, 32, e(1,0,1,0,0,0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; en = tbl[i].en; period_ld = tbl[i].ld;
            period_in = DIV_W'(tbl[i].pin); frame_ready = tbl[i].rdy;
            repeat (tbl[i].reps) step();
            check(tbl[i].name, tbl[i].exp);
        end

        // randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            rst         = ($urandom_range(0, 199) == 0);
            period_ld   = ($urandom_range(0, 39) == 0);
            period_in   = DIV_W'($urandom_range(0, 12));
            en          = ($urandom_range(0, 9) < 8);
            frame_ready = ($urandom_range(0, 1) == 1);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
